// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
//  Bundles the signals between a 7-segment scan driver and the logic around it.
//  Inputs to the driver (load, data, dp_in, blank_lz) carry the value to show.
//  Outputs from the driver (seg, dp, com, frame_tick) go to the board pins.
//  Modports:
//   master - the register/datapath side; drives the value and reads the pins.
//   slave  - the scan driver itself.
interface seg7_scan_driver_if #(
   parameter int N_DIGITS = 4
);
   logic                    load;
   logic [4*N_DIGITS-1:0]   data;
   logic [N_DIGITS-1:0]     dp_in;
   logic                    blank_lz;
   logic [6:0]              seg;
   logic                    dp;
   logic [N_DIGITS-1:0]     com;
   logic                    frame_tick;

   modport master (
      output load, data, dp_in, blank_lz,
      input  seg, dp, com, frame_tick
   );

   modport slave (
      input  load, data, dp_in, blank_lz,
      output seg, dp, com, frame_tick
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//  Time-multiplexed driver for an N-digit common-electrode 7-segment display.
//  Each digit is lit for DWELL_CYCLES clocks, separated by BLANK_CYCLES clocks
//  with every common off (anti-ghosting). Values written with load go to a
//  shadow copy and are moved into the display copy only when digit 0 starts,
//  so a frame never mixes old and new digits.
//  Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - slave side of seg7_scan_driver_if (load/data/dp_in/blank_lz in,
//           seg/dp/com/frame_tick out, all outputs registered)
module seg7_scan_driver #(
   parameter int N_DIGITS        = 4,
   parameter int DWELL_CYCLES    = 1000,
   parameter int BLANK_CYCLES    = 8,
   parameter int SEG_ACTIVE_HIGH = 1,
   parameter int COM_ACTIVE_HIGH = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seg7_scan_driver_if.slave     bus
);
   localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ?
                         ((DWELL_CYCLES > 2) ? DWELL_CYCLES : 2) :
                         ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
   localparam int CW = $clog2(MAXC);
   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int DW = 4 * N_DIGITS;

   localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
   localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

   // Inactive levels of the pins, used in reset and during blanking
   localparam logic [6:0]          SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? 7'h00 : 7'h7F;
   localparam logic                DP_OFF  = (SEG_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;
   localparam logic [N_DIGITS-1:0] COM_OFF = (COM_ACTIVE_HIGH != 0) ? '0 : '1;

   typedef enum logic {ST_BLANK, ST_SHOW} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d, idx_nxt;
   logic              frame_start;

   logic [DW-1:0]       sh_data_q, sh_data_d, dd_data_q, dd_data_d;
   logic [N_DIGITS-1:0] sh_dp_q, sh_dp_d, dd_dp_q, dd_dp_d;
   logic                sh_lz_q, sh_lz_d, dd_lz_q, dd_lz_d;
   logic                pend_q, pend_d;

   logic [6:0]          seg_q, seg_d, seg_raw;
   logic                dp_q, dp_d, dp_raw;
   logic [N_DIGITS-1:0] com_q, com_d, com_raw;
   logic                ft_q, ft_d;
   logic                show, suppress;
   logic [3:0]          nib;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1111110;  4'h1: hex7 = 7'b0110000;
         4'h2: hex7 = 7'b1101101;  4'h3: hex7 = 7'b1111001;
         4'h4: hex7 = 7'b0110011;  4'h5: hex7 = 7'b1011011;
         4'h6: hex7 = 7'b1011111;  4'h7: hex7 = 7'b1110000;
         4'h8: hex7 = 7'b1111111;  4'h9: hex7 = 7'b1111011;
         4'hA: hex7 = 7'b1110111;  4'hB: hex7 = 7'b0011111;
         4'hC: hex7 = 7'b1001110;  4'hD: hex7 = 7'b0111101;
         4'hE: hex7 = 7'b1001111;  default: hex7 = 7'b1000111;
      endcase
   endfunction

   // Scan FSM. frame_start flags the edge that enters SHOW for digit 0.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      idx_d       = idx_q;
      frame_start = 1'b0;
      idx_nxt     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      case (state_q)
         ST_BLANK: begin
            if (BLANK_CYCLES == 0 || cnt_q == BLANK_LAST) begin
               state_d     = ST_SHOW;
               cnt_d       = '0;
               frame_start = (idx_q == '0);
            end
         end
         ST_SHOW: begin
            if (cnt_q == DWELL_LAST) begin
               cnt_d = '0;
               idx_d = idx_nxt;
               // With no blank time, go straight to the next digit's SHOW
               if (BLANK_CYCLES == 0) frame_start = (idx_nxt == '0);
               else                   state_d     = ST_BLANK;
            end
         end
         default: state_d = ST_BLANK;
      endcase
   end

   // Double buffer: the frame-start copy uses the old shadow, so a load on
   // that same edge stays pending for the next frame.
   always_comb begin
      sh_data_d = bus.load ? bus.data     : sh_data_q;
      sh_dp_d   = bus.load ? bus.dp_in    : sh_dp_q;
      sh_lz_d   = bus.load ? bus.blank_lz : sh_lz_q;
      dd_data_d = dd_data_q;
      dd_dp_d   = dd_dp_q;
      dd_lz_d   = dd_lz_q;
      pend_d    = pend_q;
      if (frame_start && pend_q) begin
         dd_data_d = sh_data_q;
         dd_dp_d   = sh_dp_q;
         dd_lz_d   = sh_lz_q;
         pend_d    = 1'b0;
      end
      if (bus.load) pend_d = 1'b1;
   end

   // Output decode from the current state; registered, so pins lag the FSM by one clock
   always_comb begin
      show     = (state_q == ST_SHOW);
      nib      = dd_data_q[{idx_q, 2'b00} +: 4];
      // Digit is a leading zero when it and every more-significant nibble are 0
      suppress = dd_lz_q && (idx_q != '0) && ((dd_data_q >> {idx_q, 2'b00}) == '0);
      seg_raw  = (show && !suppress) ? hex7(nib) : 7'h00;
      dp_raw   = show && dd_dp_q[idx_q];
      com_raw  = show ? (N_DIGITS'(1) << idx_q) : '0;
      ft_d     = show && (idx_q == '0) && (cnt_q == '0);
      seg_d    = (SEG_ACTIVE_HIGH != 0) ? seg_raw : ~seg_raw;
      dp_d     = (SEG_ACTIVE_HIGH != 0) ? dp_raw  : ~dp_raw;
      com_d    = (COM_ACTIVE_HIGH != 0) ? com_raw : ~com_raw;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_BLANK;
         cnt_q     <= '0;
         idx_q     <= '0;
         sh_data_q <= '0;
         sh_dp_q   <= '0;
         sh_lz_q   <= 1'b0;
         dd_data_q <= '0;
         dd_dp_q   <= '0;
         dd_lz_q   <= 1'b0;
         pend_q    <= 1'b0;
         seg_q     <= SEG_OFF;
         dp_q      <= DP_OFF;
         com_q     <= COM_OFF;
         ft_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         sh_data_q <= sh_data_d;
         sh_dp_q   <= sh_dp_d;
         sh_lz_q   <= sh_lz_d;
         dd_data_q <= dd_data_d;
         dd_dp_q   <= dd_dp_d;
         dd_lz_q   <= dd_lz_d;
         pend_q    <= pend_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
         com_q     <= com_d;
         ft_q      <= ft_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dp         = dp_q;
   assign bus.com        = com_q;
   assign bus.frame_tick = ft_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//  Two drivers run side by side on one clock:
//   A: 4 digits, dwell 4, blank 2, active-high pins
//   B: 4 digits, dwell 3, no blank, active-low seg and com
//  A reference model tracks, per driver, the clocks since reset plus the
//  shadow/display/pending contents, and derives the expected pins from the
//  position inside the frame.
module tb_seg7_scan_driver;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   seg7_scan_driver_if #(.N_DIGITS(4)) ifa ();
   seg7_scan_driver_if #(.N_DIGITS(4)) ifb ();

   seg7_scan_driver #(.N_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2),
                      .SEG_ACTIVE_HIGH(1), .COM_ACTIVE_HIGH(1))
      dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));

   seg7_scan_driver #(.N_DIGITS(4), .DWELL_CYCLES(3), .BLANK_CYCLES(0),
                      .SEG_ACTIVE_HIGH(0), .COM_ACTIVE_HIGH(0))
      dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));

   typedef struct packed {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] com;
      logic       ft;
   } exp_t;

   localparam logic [6:0] HEX [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

   int total = 0;
   int bad   = 0;

   // Model state per driver: clocks since reset, shadow, display, pending
   int          jj   [2];
   logic [15:0] sh_d [2], dd_d [2];
   logic [3:0]  sh_p [2], dd_p [2];
   logic        sh_l [2], dd_l [2], pend [2];

   function automatic int dwell(int u); return (u == 0) ? 4 : 3; endfunction
   function automatic int blnk(int u);  return (u == 0) ? 2 : 0; endfunction

   function automatic exp_t idle(int u);
      exp_t e;
      e.seg = (u == 1) ? 7'h7F : 7'h00;
      e.dp  = (u == 1);
      e.com = (u == 1) ? 4'hF : 4'h0;
      e.ft  = 1'b0;
      return e;
   endfunction

   // Pins shown while the model sits jj[u] clocks after reset
   function automatic exp_t model_out(int u);
      exp_t e;
      int t, slot, p, dg, r;
      logic [15:0] hi;
      e = '0;
      slot = dwell(u) + blnk(u);
      // Without a blank phase the reset BLANK state still takes one clock
      t = (blnk(u) == 0) ? jj[u] - 1 : jj[u];
      if (t >= 0) begin
         p  = t % (4 * slot);
         dg = p / slot;
         r  = p % slot;
         if (r >= blnk(u)) begin
            hi    = dd_d[u] >> (4 * dg);
            e.com = 4'(1 << dg);
            e.dp  = dd_p[u][dg];
            e.ft  = (dg == 0) && (r == blnk(u));
            if (!(dd_l[u] && dg > 0 && hi == 16'h0)) e.seg = HEX[int'(hi & 16'hF)];
         end
      end
      if (u == 1) begin
         e.seg = ~e.seg;
         e.dp  = ~e.dp;
         e.com = ~e.com;
      end
      return e;
   endfunction

   task automatic model_edge(int u, logic r, logic ld, logic [15:0] dat, logic [3:0] dpi, logic lz);
      int t;
      if (!r) begin
         jj[u] = 0;  sh_d[u] = '0; sh_p[u] = '0; sh_l[u] = 1'b0;
         dd_d[u] = '0; dd_p[u] = '0; dd_l[u] = 1'b0; pend[u] = 1'b0;
      end else begin
         jj[u]++;
         t = (blnk(u) == 0) ? jj[u] - 1 : jj[u];
         if (t >= 0 && (t % (4 * (dwell(u) + blnk(u)))) == blnk(u) && pend[u]) begin
            dd_d[u] = sh_d[u]; dd_p[u] = sh_p[u]; dd_l[u] = sh_l[u]; pend[u] = 1'b0;
         end
         if (ld) begin
            sh_d[u] = dat; sh_p[u] = dpi; sh_l[u] = lz; pend[u] = 1'b1;
         end
      end
   endtask

   task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_pins(string tag, logic [6:0] s, logic d, logic [3:0] c, logic f, exp_t e);
      chk({tag, ".seg"}, 16'(s), 16'(e.seg));
      chk({tag, ".dp"},  16'(d), 16'(e.dp));
      chk({tag, ".com"}, 16'(c), 16'(e.com));
      chk({tag, ".frame_tick"}, 16'(f), 16'(e.ft));
   endtask

   // One clock: predict, apply the edge to the model, then compare away from the edge
   task automatic tick();
      exp_t e0, e1;
      logic r0, r1, l0, l1, z0, z1;
      logic [15:0] d0, d1;
      logic [3:0]  p0, p1;
      r0 = rst_a; l0 = ifa.load; d0 = ifa.data; p0 = ifa.dp_in; z0 = ifa.blank_lz;
      r1 = rst_b; l1 = ifb.load; d1 = ifb.data; p1 = ifb.dp_in; z1 = ifb.blank_lz;
      e0 = r0 ? model_out(0) : idle(0);
      e1 = r1 ? model_out(1) : idle(1);
      @(posedge clk);
      model_edge(0, r0, l0, d0, p0, z0);
      model_edge(1, r1, l1, d1, p1, z1);
      #2;
      chk_pins("A", ifa.seg, ifa.dp, ifa.com, ifa.frame_tick, e0);
      chk_pins("B", ifb.seg, ifb.dp, ifb.com, ifb.frame_tick, e1);
      // Driver B has no blank gap: once scanning, exactly one common is low
      if (r1 && jj[1] >= 2) chk("B.one_cold", 16'($countones(~ifb.com)), 16'd1);
   endtask

   task automatic run(int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic set_in(logic [15:0] d, logic [3:0] p, logic lz);
      ifa.data = d; ifa.dp_in = p; ifa.blank_lz = lz;
      ifb.data = d; ifb.dp_in = p; ifb.blank_lz = lz;
   endtask

   task automatic load_both(logic [15:0] d, logic [3:0] p, logic lz);
      set_in(d, p, lz);
      ifa.load = 1'b1; ifb.load = 1'b1;
      tick();
      ifa.load = 1'b0; ifb.load = 1'b0;
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0;
      ifa.load = 1'b0; ifb.load = 1'b0;
      set_in(16'h0, 4'h0, 1'b0);

      // Reset held for a few clocks: all pins inactive
      run(3);
      chk("rst.com_a", 16'(ifa.com), 16'h0);
      chk("rst.com_b", 16'(ifb.com), 16'hF);

      // Free-running scan of all-zero display
      rst_a = 1'b1; rst_b = 1'b1;
      run(2);
      chk("start.blank_a", 16'(ifa.com), 16'h0);
      tick();
      chk("start.d0_a", 16'(ifa.com), 16'h1);
      run(50);

      // Hex decode with a decimal point on digit 2
      load_both(16'h1A8F, 4'b0100, 1'b0);
      run(60);

      // Leading-zero suppression, then an all-zero value
      load_both(16'h0070, 4'b0000, 1'b1);
      run(60);
      load_both(16'h0000, 4'b0011, 1'b1);
      run(60);

      // Load on the exact frame-start edge of driver A
      for (int k = 0; k < 30 && (jj[0] % 24) != 3; k++) tick();
      set_in(16'h1111, 4'h0, 1'b0);
      ifa.load = 1'b1; tick(); ifa.load = 1'b0;
      for (int k = 0; k < 30 && ((jj[0] + 1) % 24) != 2; k++) tick();
      set_in(16'h2222, 4'h0, 1'b0);
      ifa.load = 1'b1; tick(); ifa.load = 1'b0;
      run(60);

      // Random loads at random times, including back-to-back
      for (int k = 0; k < 25; k++) begin
         run(int'($urandom_range(0, 20)));
         set_in(16'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
         ifa.load = 1'($urandom_range(0, 1));
         ifb.load = 1'($urandom_range(0, 1));
         tick();
         ifa.load = 1'b0; ifb.load = 1'b0;
         if (k == 12) begin
            rst_b = 1'b0; tick(); rst_b = 1'b1;
         end
      end
      run(30);

      // Reset mid-SHOW of digit 2 with a load still pending
      for (int k = 0; k < 30 && (jj[0] % 24) != 14; k++) tick();
      set_in(16'h5555, 4'hF, 1'b0);
      ifa.load = 1'b1; tick(); ifa.load = 1'b0;
      rst_a = 1'b0; tick(); rst_a = 1'b1;
      chk("abort.com", 16'(ifa.com), 16'h0);
      chk("abort.seg", 16'(ifa.seg), 16'h0);
      run(3);
      chk("restart.com", 16'(ifa.com), 16'h1);
      chk("restart.seg", 16'(ifa.seg), 16'h7E);
      run(50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
